// File: rtl/viterbi_pkg.sv
// Code parameters shared by the convolutional encoder and the Viterbi decoder,
// plus the framer state type.
package viterbi_pkg;

    localparam int         K_DEF         = 7;
    localparam logic [6:0] G0_DEF        = 7'b1111001;
    localparam logic [6:0] G1_DEF        = 7'b1011011;
    localparam int         FRAME_LEN_DEF = 642;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_e;

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 convolutional encoder core: shift register plus parity taps.
// Parity outputs are combinational on the presented bit and current state.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter int             K  = K_DEF,
    parameter logic [K-1:0]   G0 = G0_DEF,
    parameter logic [K-1:0]   G1 = G1_DEF
) (
    input  logic clk,
    input  logic RST,
    input  logic en,
    input  logic bit_in,
    output logic p0,
    output logic p1
);

    logic [K-2:0] sr_q, sr_d;
    logic [K-1:0] u;

    assign u  = {bit_in, sr_q};
    assign p0 = ^(u & G0);
    assign p1 = ^(u & G1);

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d = u[K-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/conv_encoder_framer.sv
// Frame builder around the encoder core: FRAME_LEN info bits, then K-1 zero
// tail bits so the decoder trellis ends in state 0.
module conv_encoder_framer
    import viterbi_pkg::*;
#(
    parameter int           K         = K_DEF,
    parameter logic [K-1:0] G0        = G0_DEF,
    parameter logic [K-1:0] G1        = G1_DEF,
    parameter int           FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    output logic       d_out_valid,
    output logic [1:0] d_out,
    output logic       frame_done
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(K);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_LEN);
    localparam logic [TW-1:0] TCNT_LAST = TW'(K - 2);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          dv_q, dv_d;
    logic [1:0]    dout_q, dout_d;
    logic          fd_q, fd_d;

    logic enc_en, enc_bit, p0, p1, acc;

    assign in_ready    = !RST && (state_q != TAIL);
    assign acc         = in_valid && in_ready;
    assign d_out_valid = dv_q;
    assign d_out       = dout_q;
    assign frame_done  = fd_q;

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk    (clk),
        .RST    (RST),
        .en     (enc_en),
        .bit_in (enc_bit),
        .p0     (p0),
        .p1     (p1)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        fd_d    = 1'b0;
        enc_en  = 1'b0;
        enc_bit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    enc_en  = 1'b1;
                    enc_bit = in_bit;
                    cnt_d   = CW'(1);
                    tcnt_d  = '0;
                    state_d = (FRAME_LEN == 1) ? TAIL : DATA;
                end
            end
            DATA: begin
                if (acc) begin
                    enc_en  = 1'b1;
                    enc_bit = in_bit;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_d == CNT_LAST) begin
                        tcnt_d  = '0;
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                // Zero flush runs unconditionally; input is held off
                enc_en = 1'b1;
                if (tcnt_q == TCNT_LAST) begin
                    fd_d    = 1'b1;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        dv_d   = enc_en;
        dout_d = enc_en ? {p1, p0} : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            dv_q    <= 1'b0;
            dout_q  <= 2'b00;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            dv_q    <= dv_d;
            dout_q  <= dout_d;
            fd_q    <= fd_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench: fixed vectors, random frames against a convolution
// model, reset and back-to-back corner cases, and a full default-length frame.
module tb_conv_encoder_framer;

    localparam int         N  = 8;
    localparam logic [6:0] G0 = 7'b1111001;
    localparam logic [6:0] G1 = 7'b1011011;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0, in_bit = 1'b0;
    logic       in_ready, d_out_valid, frame_done;
    logic [1:0] d_out;
    logic       in_valid2 = 1'b0, in_bit2 = 1'b0;
    logic       in_ready2, dv2, fd2;
    logic [1:0] dout2;

    int cmp_n = 0, fail_n = 0, cyc = 0;
    int fd_cnt = 0, fd_pos = 0, ir_low = 0, fd2_cnt = 0;
    logic [1:0] sym_q[$];
    int         sym_cyc[$];
    int         acc_cyc[$];
    logic [1:0] sym2_q[$];
    bit         in_q[$];
    logic [1:0] exp_q[$];

    typedef struct {
        logic [7:0]  bits;
        bit          thr;
        logic [27:0] exp;
    } vec_t;
    vec_t tbl[3];

    always #5 clk = ~clk;

    conv_encoder_framer #(.FRAME_LEN(N)) dut (
        .clk         (clk),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bit      (in_bit),
        .d_out_valid (d_out_valid),
        .d_out       (d_out),
        .frame_done  (frame_done)
    );

    conv_encoder_framer dut2 (
        .clk         (clk),
        .RST         (RST),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .in_bit      (in_bit2),
        .d_out_valid (dv2),
        .d_out       (dout2),
        .frame_done  (fd2)
    );

    always @(negedge clk) begin
        cyc++;
        if (!RST) begin
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (d_out_valid) begin
                sym_q.push_back(d_out);
                sym_cyc.push_back(cyc);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_pos = sym_q.size();
            end
            if (!in_ready) ir_low++;
            if (dv2) sym2_q.push_back(dout2);
            if (fd2) fd2_cnt++;
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear();
        sym_q.delete();
        sym_cyc.delete();
        acc_cyc.delete();
        sym2_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        fd_pos = 0;
        ir_low = 0;
        fd2_cnt = 0;
    endtask

    // Symbol t is the XOR-convolution of the zero-padded bit stream with each
    // generator; tap j of the generator weights the bit j steps in the past.
    function automatic void model_frame(input int s, input int len);
        for (int t = 0; t < len + 6; t++) begin
            logic a, b;
            a = 1'b0;
            b = 1'b0;
            for (int j = 0; j < 7; j++) begin
                if (t - j >= 0 && t - j < len) begin
                    a ^= G0[6-j] & in_q[s+t-j];
                    b ^= G1[6-j] & in_q[s+t-j];
                end
            end
            exp_q.push_back({b, a});
        end
    endfunction

    task automatic drive(input bit thr);
        int i = 0;
        int k = 0;
        while (i < in_q.size() && k < 400) begin
            in_valid = thr ? ~k[0] : 1'b1;
            in_bit   = in_q[i];
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk);
            #1;
            k++;
        end
        check("feed", i, in_q.size());
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int nf);
        int k = 0;
        while (fd_cnt < nf && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string nm, input int nf);
        int bad = 0;
        int tbad = 0;
        check({nm, " count"}, sym_q.size(), exp_q.size());
        for (int i = 0; i < sym_q.size() && i < exp_q.size(); i++)
            if (sym_q[i] !== exp_q[i]) bad++;
        check({nm, " symbols"}, bad, 0);
        check({nm, " frame_done"}, fd_cnt, nf);
        check({nm, " done_pos"}, fd_pos, exp_q.size());
        check({nm, " ready_low"}, ir_low, 6 * nf);
        if (sym_q.size() == nf * (N + 6) && acc_cyc.size() == nf * N) begin
            for (int i = 0; i < nf * N; i++)
                if (sym_cyc[i + (i / N) * 6] != acc_cyc[i] + 1) tbad++;
            for (int f = 0; f < nf; f++)
                for (int j = 0; j < 6; j++)
                    if (sym_cyc[f*(N+6)+N+j] != sym_cyc[f*(N+6)+N-1] + 1 + j)
                        tbad++;
        end else begin
            tbad = -1;
        end
        check({nm, " timing"}, tbad, 0);
    endtask

    initial begin
        tbl[0] = '{bits: 8'h00, thr: 1'b0, exp: 28'h0};
        tbl[1] = '{bits: 8'h01, thr: 1'b0,
                   exp: {14'b0, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11}};
        tbl[2] = '{bits: 8'h01, thr: 1'b1,
                   exp: {14'b0, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11}};

        RST = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst in_ready", in_ready, 0);
        check("rst d_out_valid", d_out_valid, 0);
        check("rst d_out", d_out, 0);
        check("rst frame_done", frame_done, 0);
        check("rst sr", dut.u_core.sr_q, 0);
        @(posedge clk);
        #1;
        RST = 1'b0;
        @(negedge clk);
        check("post-rst in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 3; v++) begin
            clear();
            in_q.delete();
            for (int i = 0; i < N; i++) in_q.push_back(tbl[v].bits[i]);
            for (int i = 0; i < N + 6; i++) exp_q.push_back(tbl[v].exp[2*i +: 2]);
            drive(tbl[v].thr);
            wait_done(1);
            check_frame($sformatf("vec%0d", v), 1);
        end

        for (int r = 0; r < 6; r++) begin
            clear();
            in_q.delete();
            for (int i = 0; i < N; i++) in_q.push_back(1'($urandom_range(0, 1)));
            model_frame(0, N);
            drive(1'($urandom_range(0, 1)));
            wait_done(1);
            check_frame($sformatf("rand%0d", r), 1);
        end

        clear();
        in_q.delete();
        for (int i = 0; i < 2 * N; i++) in_q.push_back(1'($urandom_range(0, 1)));
        model_frame(0, N);
        model_frame(N, N);
        drive(1'b0);
        wait_done(2);
        check_frame("b2b", 2);

        clear();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_bit = 1'b1;
            @(posedge clk);
            #1;
        end
        in_bit = 1'b1;
        RST = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst d_out_valid", d_out_valid, 0);
        check("midrst sr", dut.u_core.sr_q, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        RST = 1'b0;
        fd_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        check("midrst no done", fd_cnt, 0);
        clear();
        in_q.delete();
        for (int i = 0; i < N; i++) in_q.push_back(1'b0);
        model_frame(0, N);
        drive(1'b0);
        wait_done(1);
        check_frame("post-rst zero", 1);

        clear();
        in_q.delete();
        for (int i = 0; i < 642; i++) in_q.push_back(1'($urandom_range(0, 1)));
        model_frame(0, 642);
        begin
            int i = 0;
            int k = 0;
            int bad = 0;
            while (i < 642 && k < 2000) begin
                in_valid2 = 1'b1;
                in_bit2   = in_q[i];
                @(negedge clk);
                if (in_ready2) i++;
                @(posedge clk);
                #1;
                k++;
            end
            in_valid2 = 1'b0;
            k = 0;
            while (fd2_cnt < 1 && k < 100) begin
                @(posedge clk);
                k++;
            end
            repeat (2) @(posedge clk);
            #1;
            check("full count", sym2_q.size(), 648);
            for (int j = 0; j < sym2_q.size() && j < exp_q.size(); j++)
                if (sym2_q[j] !== exp_q[j]) bad++;
            check("full symbols", bad, 0);
            check("full frame_done", fd2_cnt, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
